nbcac_tx_scheduler: RTL and testbench

NBCAC_TX_SCHEDULER -- requirements
Module: nbcac_tx_scheduler

---
 rtl/nbcac_pkg.sv | 34 +++
 rtl/nbcac_tx_scheduler_if.sv | 25 ++
 rtl/nbcac_10di_encoder_core.sv | 18 +
 rtl/nbcac_tx_scheduler.sv | 115 +++++++++++
 tb/tb_nbcac_tx_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nbcac_pkg.sv
// Shared definitions for the NBCAC transmit scheduler: widths, FSM states
// and the round-robin search used by the arbiter.
package nbcac_pkg;

  localparam int DATA_W = 10;
  localparam int CODE_W = 14;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Returns the first set bit of valid at or after start, wrapping modulo n.
  // n is at most 8; callers check separately that some bit is set.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] start,
                                         input int unsigned n);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = {1'b0, start} + 4'(k);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if ((k < n) && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/nbcac_tx_scheduler_if.sv
// Requester and downstream handshake bundle of the NBCAC scheduler.
// master: the side offering words and consuming codewords; slave: scheduler.
interface nbcac_tx_scheduler_if import nbcac_pkg::*; #(
  parameter int NUM_REQ = 4
) ();
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [NUM_REQ-1:0]        in_ready;
  logic                      out_valid;
  logic [CODE_W:1]           out_code;
  logic [SRC_W-1:0]          out_src;
  logic                      out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_src
  );
endinterface

// File: rtl/nbcac_10di_encoder_core.sv
// Combinational 10-bit to 14-bit crosstalk-avoidance encoder.
// Data is sent as five bit pairs; the upper bit of each of the first four
// pairs is duplicated on the wire next to it, acting as a half shield.
module nbcac_10di_encoder_core import nbcac_pkg::*; (
  input  logic [DATA_W-1:0] data_i,
  output logic [CODE_W:1]   code_o
);

  // Wire position 3k+1/3k+2 carry pair k, 3k+3 repeats its upper bit.
  for (genvar gi = 0; gi < 5; gi++) begin : g_pair
    assign code_o[3*gi+1] = data_i[2*gi];
    assign code_o[3*gi+2] = data_i[2*gi+1];
    if (gi < 4) begin : g_dup
      assign code_o[3*gi+3] = data_i[2*gi+1];
    end
  end

endmodule

// File: rtl/nbcac_tx_scheduler.sv
// Burst-limited round-robin scheduler sharing one NBCAC encoder among
// NUM_REQ requesters, with a single registered output stage.
module nbcac_tx_scheduler import nbcac_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input logic                 clock,
  input logic                 rst_n,
  nbcac_tx_scheduler_if.slave bus
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    holder_q, holder_d;
  logic [BC_W-1:0]     bc_q, bc_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [CODE_W:1]     out_code_q, out_code_d;
  logic [SRC_W-1:0]    out_src_q, out_src_d;

  logic                any_valid;
  logic                can_load;
  logic                load;
  logic                keep;
  logic [SRC_W-1:0]    rr_base;
  logic [SRC_W-1:0]    rr_start;
  logic [SRC_W-1:0]    grant;
  logic [DATA_W-1:0]   data_sel;
  logic [CODE_W:1]     enc_code;

  // Arbitration: keep the holder while it is valid and under its burst
  // limit, otherwise search round-robin past the holder (or past ptr).
  always_comb begin
    any_valid = |bus.in_valid;
    can_load  = !out_valid_q || bus.out_ready;
    load      = can_load && any_valid;
    keep      = (state_q == LOCK) && bus.in_valid[holder_q] &&
                (bc_q < BC_W'(MAX_BURST));
    rr_base   = (state_q == LOCK) ? holder_q : ptr_q;
    rr_start  = (rr_base == SRC_W'(NUM_REQ - 1)) ? '0 : rr_base + 1'b1;
    grant     = keep ? holder_q
                     : SRC_W'(rr_pick(8'(bus.in_valid), 3'(rr_start), NUM_REQ));
    data_sel  = bus.in_data[grant*DATA_W +: DATA_W];
  end

  // One-hot accept strobe; forced low while reset is asserted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign bus.in_ready[gi] = rst_n && load && (grant == SRC_W'(gi));
  end

  nbcac_10di_encoder_core u_enc (
    .data_i (data_sel),
    .code_o (enc_code)
  );

  // Next-state: capture on load, drain when consumed, release holder when idle.
  always_comb begin
    state_d     = state_q;
    holder_d    = holder_q;
    bc_d        = bc_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_code_d  = enc_code;
      out_src_d   = grant;
      state_d     = LOCK;
      if (keep) begin
        bc_d = bc_q + 1'b1;
      end else begin
        holder_d = grant;
        bc_d     = BC_W'(1);
        if (state_q == LOCK) ptr_d = holder_q;
      end
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
      // Nobody valid and the output can move: holder lets go.
      if (can_load && (state_q == LOCK)) begin
        state_d = IDLE;
        ptr_d   = holder_q;
        bc_d    = '0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      holder_q    <= '0;
      bc_q        <= '0;
      ptr_q       <= SRC_W'(NUM_REQ - 1);
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      holder_q    <= holder_d;
      bc_q        <= bc_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_nbcac_tx_scheduler.sv
// Scoreboard bench for nbcac_tx_scheduler: expected sources are queued as
// stimulus is applied and checked, with their codewords, on delivery.
module tb_nbcac_tx_scheduler;
  import nbcac_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int SW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nbcac_tx_scheduler_if #(.NUM_REQ(N)) bus ();

  nbcac_tx_scheduler #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cnt  [N];
  int         dcnt [N];
  int         exp_q[$];
  logic [N-1:0] acc;

  // Word k offered by requester i; requester 1's first word is 10'h3FF.
  function automatic logic [9:0] word(input int i, input int k);
    logic [9:0] a, b;
    a = 10'(k * 37);
    b = 10'((i ^ 1) * 213);
    return 10'h3FF ^ a ^ b;
  endfunction

  // Reference encoder: wire bit j lies in group j/3; slot 0 is the pair's
  // lower bit, slots 1 and 2 both carry its upper bit.
  function automatic logic [13:0] enc_model(input logic [9:0] d);
    logic [13:0] c;
    for (int j = 0; j < 14; j++) c[j] = d[2*(j/3) + (((j % 3) == 0) ? 0 : 1)];
    return c;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) bus.in_data[i*10 +: 10] = word(i, cnt[i]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 0;
      dcnt[i] = 0;
    end
    exp_q.delete();
    drive_data();
  endtask

  // Negedge sampling: record accepts, check handshake legality and deliveries.
  task automatic sample();
    int s;
    logic [13:0] e;
    @(negedge clk);
    acc = bus.in_ready & bus.in_valid;
    if (rst_n) begin
      checks++;
      if (!$onehot0(bus.in_ready) || ((bus.in_ready & ~bus.in_valid) != '0)) begin
        failures++;
        $display("FAIL in_ready_legal: in_ready=%b in_valid=%b", bus.in_ready, bus.in_valid);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: src=%0d code=%h, none required", bus.out_src, bus.out_code);
        end else begin
          s = exp_q.pop_front();
          e = enc_model(word(s, dcnt[s]));
          dcnt[s]++;
          if (bus.out_src !== SW'(s) || bus.out_code !== e) begin
            failures++;
            $display("FAIL delivered_word: src=%0d code=%h, required src=%0d code=%h",
                     bus.out_src, bus.out_code, s, e);
          end else begin
            $display("word src=%0d code=%h", bus.out_src, bus.out_code);
          end
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) cnt[i]++;
    drive_data();
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic run_accepts(input int target, input int bound);
    int total = 0;
    int n = 0;
    while (total < target && n < bound) begin
      sample();
      total += $countones(acc);
      advance();
      n++;
    end
    checks++;
    if (total < target) begin
      failures++;
      $display("FAIL accept_timeout: got %0d accepts, required %0d", total, target);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: %0d words outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    clear_model();
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (bus.in_ready !== '0) begin
        failures++;
        $display("FAIL reset_in_ready: got %b required 0000", bus.in_ready);
      end
      if (c == 2) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_code !== 14'h0 || bus.out_src !== '0) begin
          failures++;
          $display("FAIL reset_outputs: valid=%b code=%h src=%0d required 0/0/0",
                   bus.out_valid, bus.out_code, bus.out_src);
        end
      end
      advance();
    end
    bus.in_valid = '0;
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b1;
    exp_q.push_back(1);
    sample();
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL single_in_ready: got %b required 0010", bus.in_ready);
    end
    advance();
    bus.in_valid = '0;
    sample();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== SW'(1) || bus.out_code !== 14'h3FFF) begin
      failures++;
      $display("FAIL single_out: valid=%b src=%0d code=%h required 1/1/3fff",
               bus.out_valid, bus.out_src, bus.out_code);
    end
    advance();
    sample();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_clear: out_valid=%b required 0", bus.out_valid);
    end
    advance();
    check_drained("single");
  endtask

  task automatic test_burst_rotation();
    do_reset();
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    for (int s = 0; s < 4; s++) repeat (4) exp_q.push_back(s);
    exp_q.push_back(0);
    run_accepts(17, 40);
    bus.in_valid = '0;
    cycle();
    check_drained("burst");
  endtask

  task automatic test_idle_hold();
    logic [13:0] last;
    last = enc_model(word(0, 4));
    for (int c = 0; c < 10; c++) begin
      sample();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_code !== last) begin
        failures++;
        $display("FAIL idle_hold: valid=%b code=%h required 0/%h", bus.out_valid, bus.out_code, last);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] held;
    do_reset();
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(0);
    held = enc_model(word(0, 0));
    cycle();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++;
      if (bus.in_ready !== '0 || bus.out_valid !== 1'b1 || bus.out_src !== SW'(0) ||
          bus.out_code !== held) begin
        failures++;
        $display("FAIL stall_hold: in_ready=%b valid=%b src=%0d code=%h required 0000/1/0/%h",
                 bus.in_ready, bus.out_valid, bus.out_src, bus.out_code, held);
      end
      advance();
    end
    bus.out_ready = 1'b1;
    sample();
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL stall_release_ready: got %b required 0001", bus.in_ready);
    end
    advance();
    bus.in_valid = '0;
    sample();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== enc_model(word(0, 1))) begin
      failures++;
      $display("FAIL stall_next_word: valid=%b code=%h required 1/%h",
               bus.out_valid, bus.out_code, enc_model(word(0, 1)));
    end
    advance();
    cycle();
    check_drained("backpressure");
  endtask

  task automatic test_early_release();
    logic [N-1:0] want [3];
    want[0] = 4'b0100;
    want[1] = 4'b0100;
    want[2] = 4'b1000;
    do_reset();
    bus.in_valid  = 4'b1100;
    bus.out_ready = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(2);
    exp_q.push_back(3);
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (bus.in_ready !== want[c]) begin
        failures++;
        $display("FAIL early_release_ready%0d: got %b required %b", c, bus.in_ready, want[c]);
      end
      advance();
      if (cnt[2] == 2) bus.in_valid[2] = 1'b0;
    end
    bus.in_valid = '0;
    sample();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== SW'(3)) begin
      failures++;
      $display("FAIL early_release_src: valid=%b src=%0d required 1/3", bus.out_valid, bus.out_src);
    end
    advance();
    cycle();
    check_drained("early_release");
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    repeat (3) exp_q.push_back(0);
    run_accepts(3, 10);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++;
      if (bus.in_ready !== '0) begin
        failures++;
        $display("FAIL midreset_in_ready: got %b required 0000", bus.in_ready);
      end
      if (c == 1) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_code !== 14'h0) begin
          failures++;
          $display("FAIL midreset_out: valid=%b code=%h required 0/0000", bus.out_valid, bus.out_code);
        end
      end
      advance();
    end
    clear_model();
    rst_n = 1'b1;
    exp_q.push_back(0);
    sample();
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_first_grant: got %b required 0001", bus.in_ready);
    end
    advance();
    bus.in_valid = '0;
    cycle();
    cycle();
    check_drained("reset_mid");
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    acc           = '0;
    test_reset();
    test_single();
    test_burst_rotation();
    test_idle_hold();
    test_backpressure();
    test_early_release();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
